// File: rtl/phase_sequencer_ctrl.sv
// VeriRISC control unit: 8-phase instruction sequencer with HALTED/resume and a retired-instruction count.
// Optional memory-wait stall is compiled in with CTRL_STALL_EN (default build: fixed 8 cycles per instruction).
module phase_sequencer_ctrl #(
   parameter int OPC_W = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero,
   input  logic             mem_ready,
   input  logic             resume,
   output logic             sel,
   output logic             rd,
   output logic             ld_ir,
   output logic             halt,
   output logic             inc_pc,
   output logic             ld_ac,
   output logic             wr,
   output logic             ld_pc,
   output logic             data_e,
   output logic [2:0]       phase,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [2:0]       phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       op_known;
   logic [2:0] op;
   logic       is_alu, is_hlt, is_skz, is_jmp, is_sto;
   logic       stall;

   // Wider opcodes with any bit above the low three set decode as NOP.
   assign op_known = ((opcode >> 3) == '0);
   assign op       = opcode[2:0];
   assign is_alu   = op_known && (op == OP_ADD || op == OP_AND || op == OP_XOR || op == OP_LDA);
   assign is_hlt   = op_known && (op == OP_HLT);
   assign is_skz   = op_known && (op == OP_SKZ);
   assign is_jmp   = op_known && (op == OP_JMP);
   assign is_sto   = op_known && (op == OP_STO);

`ifndef CTRL_STALL_EN
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         phase_q <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      sel     = 1'b0;
      rd      = 1'b0;
      ld_ir   = 1'b0;
      halt    = 1'b0;
      inc_pc  = 1'b0;
      ld_ac   = 1'b0;
      wr      = 1'b0;
      ld_pc   = 1'b0;
      data_e  = 1'b0;
      stall   = 1'b0;

      case (state_q)
         ST_RUN: begin
            case (phase_q)
               3'd0: sel = 1'b1;
               3'd1: begin sel = 1'b1; rd = 1'b1; end
               3'd2, 3'd3: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
               3'd4: begin inc_pc = 1'b1; halt = is_hlt; end
               3'd5: rd = is_alu;
               3'd6: begin
                  rd     = is_alu;
                  inc_pc = is_skz && zero;
                  ld_pc  = is_jmp;
                  data_e = is_sto;
               end
               default: begin
                  rd     = is_alu;
                  ld_ac  = is_alu;
                  ld_pc  = is_jmp;
                  wr     = is_sto;
                  data_e = is_sto;
               end
            endcase

`ifdef CTRL_STALL_EN
            // Memory-facing phases wait for mem_ready; side-effect strobes are held off until then.
            stall = (rd || wr) && !mem_ready && (phase_q != 3'd0) && (phase_q != 3'd4);
            if (stall) begin
               ld_ir  = 1'b0;
               ld_ac  = 1'b0;
               wr     = 1'b0;
               ld_pc  = 1'b0;
               inc_pc = 1'b0;
            end
`endif

            if (stall) begin
               phase_d = phase_q;
            end else if (phase_q == 3'd4 && is_hlt) begin
               state_d = ST_HALTED;
               phase_d = 3'd0;
               cnt_d   = cnt_q + 1'b1;
            end else begin
               phase_d = phase_q + 3'd1;
               if (phase_q == 3'd7) cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            halt = 1'b1;
            if (resume) begin
               state_d = ST_RUN;
               phase_d = 3'd0;
            end
         end
      endcase
   end

   assign phase     = phase_q;
   assign halted    = (state_q == ST_HALTED);
   assign instr_cnt = cnt_q;

endmodule
